// File: rtl/hc02_tester.sv
// Self-running tester for a quad 2-input NOR device: drives vectors 00,01,10,11 to every gate and flags each y that differs from ~(a|b).
// Optional macro HC02_TESTER_SYNC_EN adds a 2-flop synchronizer on y_in, which lengthens each settle window by two cycles.
module hc02_tester #(
  parameter int NUM_GATES     = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [NUM_GATES-1:0] a_out,
  output logic [NUM_GATES-1:0] b_out,
  input  logic [NUM_GATES-1:0] y_in,
  output logic [1:0]           vec_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_GATES-1:0] fail_mask
);

  logic [NUM_GATES-1:0] y_cmp;

`ifdef HC02_TESTER_SYNC_EN
  localparam int CMP_AT = SETTLE_CYCLES + 2;
  logic [NUM_GATES-1:0] y_sync1_q, y_sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_sync1_q <= '0;
      y_sync2_q <= '0;
    end else begin
      y_sync1_q <= y_in;
      y_sync2_q <= y_sync1_q;
    end
  end
  assign y_cmp = y_sync2_q;
`else
  localparam int CMP_AT = SETTLE_CYCLES;
  assign y_cmp = y_in;
`endif

  localparam int CW = (CMP_AT < 2) ? 1 : $clog2(CMP_AT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           vec_q, vec_d, vec_nxt;
  logic [NUM_GATES-1:0] a_q, a_d, b_q, b_d, fail_q, fail_d, mism;
  logic                 busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  // Mismatches are always taken against the vector currently on the pins.
  assign mism    = y_cmp ^ ~(a_q | b_q);
  assign vec_nxt = vec_q + 2'd1;

  always_comb begin
    // NOTE: every _d starts from its hold value so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    a_d     = a_q;
    b_d     = b_q;
    fail_d  = fail_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        a_d = '0;
        b_d = '0;
        if (start) begin
          vec_d   = 2'd0;
          fail_d  = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == CW'(CMP_AT - 1)) begin
          fail_d = fail_q | mism;
          cnt_d  = '0;
          if (vec_q != 2'd3) begin
            vec_d = vec_nxt;
            a_d   = {NUM_GATES{vec_nxt[1]}};
            b_d   = {NUM_GATES{vec_nxt[0]}};
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = ~|(fail_q | mism);
            a_d     = '0;
            b_d     = '0;
            vec_d   = 2'd0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      fail_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign vec_idx   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_q;

endmodule
